mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 1024×32 synchronous data memory between the instruction-fetch path (port 0) and the load/store path (port 1). Each cycle it grants at most one request and drives the memory's write enable, address and write data. It returns registered read data and a one-cycle valid pulse to the owning requester. The load/store port has fixed priority, bounded by a starvation counter that guarantees fetch progress.

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous data memory between the
// instruction-fetch port (m0) and the load/store port (m1). Port 1 has fixed
// priority; a saturating wait counter forces a port 0 grant after MAX_WAIT
// consecutive denied cycles. Reads return through a two-stage pipeline.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              s1_vld_q, s1_vld_d;
  logic              s1_own_q, s1_own_d;
  // Stage 2 is held as per-port valid flags: the owner bit is implied by
  // which of the two flags is set.
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  // Grant selection: sole requester wins, on contention port 1 unless port 0 has waited MAX_WAIT cycles.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        if (wait_q == WAIT_LIMIT) begin
          m0_gnt = 1'b1;
        end else begin
          m1_gnt = 1'b1;
        end
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  // Memory command mux: the winner's command, or all zeros when idle.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (m0_gnt) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_din  = m0_wdata;
    end else if (m1_gnt) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_din  = m1_wdata;
    end
  end

  // Next-state for the starvation counter and the read-return pipeline.
  always_comb begin
    wait_d      = wait_q;
    s1_vld_d    = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
    s1_own_d    = m1_gnt;
    m0_rvalid_d = s1_vld_q && !s1_own_q;
    m1_rvalid_d = s1_vld_q && s1_own_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;

    if (!m0_req || m0_gnt) begin
      wait_d = '0;
    end else if (wait_q < WAIT_LIMIT) begin
      wait_d = wait_q + CNT_W'(1);
    end

    if (m0_rvalid_d) begin
      m0_rdata_d = mem_dout;
    end
    if (m1_rvalid_d) begin
      m1_rdata_d = mem_dout;
    end
  end

  // State registers with synchronous active-low reset; reset discards in-flight reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_own_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      wait_q      <= wait_d;
      s1_vld_q    <= s1_vld_d;
      s1_own_q    <= s1_own_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: external memory model, transaction-level
// reference (shadow memory + queue of expected read returns), and per-feature
// directed and random scenarios.
module tb_mem_arbiter;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXW = 4;
  localparam int unsigned VW   = 3 + AW + DW + 2 + 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous 1024x32 memory.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  // Reference model state.
  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] er0, er1;
  int            mw;
  int            cyc;
  bit            eg0, eg1;
  logic [VW-1:0] exp_vec;
  int            total, bad;

  function automatic logic [VW-1:0] obs();
    return {m0_gnt, m1_gnt, mem_we, mem_addr, mem_din,
            m0_rvalid, m1_rvalid, m0_rdata, m1_rdata};
  endfunction

  // Expected outputs for the current cycle from the arbitration rules and pending reads.
  task automatic predict();
    logic          we_e;
    logic [AW-1:0] a_e;
    logic [DW-1:0] d_e;
    bit            erv0, erv1;
    #1;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (rst_n === 1'b1) begin
      if (m0_req && m1_req) begin
        if (mw == int'(MAXW)) eg0 = 1'b1;
        else                  eg1 = 1'b1;
      end else begin
        eg0 = m0_req;
        eg1 = m1_req;
      end
    end
    we_e = 1'b0; a_e = '0; d_e = '0;
    if (eg0) begin we_e = m0_we; a_e = m0_addr; d_e = m0_wdata; end
    if (eg1) begin we_e = m1_we; a_e = m1_addr; d_e = m1_wdata; end
    erv0 = 1'b0;
    erv1 = 1'b0;
    while (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].port) begin erv1 = 1'b1; er1 = pend[0].data; end
      else              begin erv0 = 1'b1; er0 = pend[0].data; end
      void'(pend.pop_front());
    end
    exp_vec = {eg0, eg1, we_e, a_e, d_e, erv0, erv1, er0, er1};
  endtask

  // Apply the clock edge to the model and move to the next drive point.
  task automatic advance();
    bit            p;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd_t           r;
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      mw = 0;
      pend.delete();
      er0 = '0;
      er1 = '0;
    end else begin
      if (eg0 || eg1) begin
        p  = eg1;
        we = p ? m1_we : m0_we;
        a  = p ? m1_addr : m0_addr;
        d  = p ? m1_wdata : m0_wdata;
        if (we) begin
          shadow[a[3:0]] = d;
        end else begin
          r.port = p; r.data = shadow[a[3:0]]; r.due = cyc + 2;
          pend.push_back(r);
        end
      end
      if (!m0_req || eg0) mw = 0;
      else if (mw < int'(MAXW)) mw = mw + 1;
    end
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic idle_ports();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] o;
    idle_ports();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'd3; m0_wdata = 32'h1234;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'd4; m1_wdata = 32'h5678;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        rst_n = 1'b1;
        idle_ports();
      end
      predict();
      o = obs();
      total++;
      if (o !== exp_vec) begin
        bad++; $display("FAIL reset_vec cyc=%0d got=%h want=%h", cyc, o, exp_vec);
      end
      total++;
      if (k < 3 && {m0_gnt, m1_gnt, mem_we} !== 3'b000) begin
        bad++; $display("FAIL reset_gnt cyc=%0d got=%b want=000", cyc, {m0_gnt, m1_gnt, mem_we});
      end
      total++;
      if (k >= 3 && {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
        bad++; $display("FAIL reset_out cyc=%0d got=%b/%b %h %h want=0", cyc, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
      end
      advance();
    end
  endtask

  task automatic test_preload();
    logic [VW-1:0] o;
    for (int i = 0; i < 16; i++) begin
      idle_ports();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = AW'(i);
      m1_wdata = (i >= 1 && i <= 3) ? DW'(i * 32'h11) : $urandom;
      predict();
      o = obs();
      total++;
      if (o !== exp_vec) begin
        bad++; $display("FAIL preload cyc=%0d got=%h want=%h", cyc, o, exp_vec);
      end
      advance();
    end
    idle_ports();
  endtask

  task automatic test_write_read();
    logic [VW-1:0] o;
    for (int k = 0; k < 6; k++) begin
      idle_ports();
      if (k == 0) begin
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'd5; m1_wdata = 32'hDEADBEEF;
      end
      if (k == 1) begin
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd5;
      end
      predict();
      o = obs();
      total++;
      if (o !== exp_vec) begin
        bad++; $display("FAIL wr_rd_vec cyc=%0d got=%h want=%h", cyc, o, exp_vec);
      end
      total++;
      if (m0_rvalid !== (k == 3) || m1_rvalid !== 1'b0) begin
        bad++; $display("FAIL wr_rd_valid k=%0d got=%b%b want=%b0", k, m0_rvalid, m1_rvalid, k == 3);
      end
      if (k == 3) begin
        total++;
        if (m0_rdata !== 32'hDEADBEEF) begin
          bad++; $display("FAIL wr_rd_data got=%h want=deadbeef", m0_rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_contention();
    logic [VW-1:0] o;
    idle_ports();
    predict(); advance();
    for (int k = 0; k < 20; k++) begin
      if (k < 15) begin
        if (k == 0 || eg0) m0_addr = AW'($urandom_range(15));
        if (k == 0 || eg1) m1_addr = AW'($urandom_range(15));
        m0_req = 1'b1; m0_we = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0;
      end else begin
        idle_ports();
      end
      predict();
      o = obs();
      total++;
      if (o !== exp_vec) begin
        bad++; $display("FAIL contend_vec cyc=%0d got=%h want=%h", cyc, o, exp_vec);
      end
      if (k < 15) begin
        total++;
        if ({m0_gnt, m1_gnt} !== (((k % 5) == 4) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL contend_pattern k=%0d got=%b%b want=%0s", k, m0_gnt, m1_gnt, ((k % 5) == 4) ? "10" : "01");
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] o;
    logic [DW-1:0] want;
    for (int k = 0; k < 8; k++) begin
      idle_ports();
      if (k < 3) begin
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = AW'(k + 1);
      end
      predict();
      o = obs();
      total++;
      if (o !== exp_vec) begin
        bad++; $display("FAIL b2b_vec cyc=%0d got=%h want=%h", cyc, o, exp_vec);
      end
      total++;
      if (m1_rvalid !== (k >= 2 && k <= 4)) begin
        bad++; $display("FAIL b2b_valid k=%0d got=%b want=%b", k, m1_rvalid, k >= 2 && k <= 4);
      end
      if (k >= 2) begin
        want = (k <= 4) ? DW'((k - 1) * 32'h11) : 32'h33;
        total++;
        if (m1_rdata !== want) begin
          bad++; $display("FAIL b2b_data k=%0d got=%h want=%h", k, m1_rdata, want);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_read();
    logic [VW-1:0] o;
    for (int k = 0; k < 14; k++) begin
      idle_ports();
      rst_n = (k == 1) ? 1'b0 : 1'b1;
      if (k == 0) begin
        m0_req = 1'b1; m0_addr = 10'd7;
        m1_req = 1'b1; m1_addr = 10'd2;
      end
      if (k >= 3) begin
        m0_req = 1'b1; m0_addr = 10'd1;
        m1_req = 1'b1; m1_addr = 10'd3;
      end
      predict();
      o = obs();
      total++;
      if (o !== exp_vec) begin
        bad++; $display("FAIL rst_mid_vec cyc=%0d got=%h want=%h", cyc, o, exp_vec);
      end
      if (k >= 1 && k <= 4) begin
        total++;
        if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0) begin
          bad++; $display("FAIL rst_mid_valid k=%0d got=%b%b want=00", k, m0_rvalid, m1_rvalid);
        end
      end
      if (k == 7) begin
        total++;
        if (m0_gnt !== 1'b1) begin
          bad++; $display("FAIL rst_mid_waitcnt got=%b want=1", m0_gnt);
        end
      end
      advance();
    end
    idle_ports();
    for (int k = 0; k < 3; k++) begin
      predict();
      o = obs();
      total++;
      if (o !== exp_vec) begin
        bad++; $display("FAIL rst_mid_drain cyc=%0d got=%h want=%h", cyc, o, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] o;
    idle_ports();
    for (int k = 0; k < 400; k++) begin
      if (k < 395) begin
        if (!m0_req || eg0) begin
          m0_req   = ($urandom_range(3) != 0);
          m0_we    = ($urandom_range(2) == 0);
          m0_addr  = AW'($urandom_range(15));
          m0_wdata = $urandom;
        end
        if (!m1_req || eg1) begin
          m1_req   = ($urandom_range(3) != 0);
          m1_we    = ($urandom_range(2) == 0);
          m1_addr  = AW'($urandom_range(15));
          m1_wdata = $urandom;
        end
      end else begin
        idle_ports();
      end
      predict();
      o = obs();
      total++;
      if (o !== exp_vec) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, o, exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; mw = 0;
    er0 = '0; er1 = '0;
    eg0 = 1'b0; eg1 = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    rst_n = 1'b0;
    idle_ports();
    @(negedge clk);
    test_reset();
    test_preload();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
